// File: rtl/exec_controller.sv
// Run/step/halt execution controller for a single-cycle core: run switch, debounced step button, ebreak and breakpoint halting.
// Optional PC breakpoint support is compiled in when EXEC_CTRL_BREAKPOINT_EN is defined.
module exec_controller #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_req,
  input  logic        step_btn,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        halted,
  output logic [31:0] retired
);

  localparam logic [31:0] EBREAK_INSTR = 32'h00100073;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [1:0]       run_sync;
  logic [1:0]       step_sync;
  logic             run_s;
  logic             step_s;
  logic [CNT_W-1:0] db_cnt;
  logic             db_level;
  logic             step_pulse;
  logic             ebreak_hit;
  logic             bp_hit;

  // NOTE: every register here resets synchronously, so rst is only looked at inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_sync  <= '0;
      step_sync <= '0;
    end else begin
      run_sync  <= {run_sync[0], run_req};
      step_sync <= {step_sync[0], step_btn};
    end
  end

  assign run_s  = run_sync[1];
  assign step_s = step_sync[1];

  // A level is accepted only after DEBOUNCE_CYCLES consecutive samples that differ from the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt     <= '0;
      db_level   <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (step_s == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
        db_cnt     <= '0;
        db_level   <= step_s;
        step_pulse <= step_s;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  assign ebreak_hit = (instr == EBREAK_INSTR);

`ifdef EXEC_CTRL_BREAKPOINT_EN
  logic bp_skip;

  assign bp_hit = bp_en && (pc == bp_addr) && !bp_skip;

  // Masks the breakpoint for the first enabled cycle after entering RUN, so a resume executes it once.
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_skip <= 1'b0;
    end else if ((cur_state == IDLE) && run_s) begin
      bp_skip <= 1'b1;
    end else if (cpu_en) begin
      bp_skip <= 1'b0;
    end
  end
`else
  logic unused_bp;

  assign bp_hit    = 1'b0;
  assign unused_bp = bp_en ^ (^bp_addr) ^ (^pc);
`endif

  assign cpu_en = ((cur_state == RUN) && !ebreak_hit && !bp_hit) ||
                  ((cur_state == STEP) && !ebreak_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // NOTE: nxt_state gets its default before the case, so no path leaves it unassigned and no latch appears.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE: begin
        if (run_s) begin
          nxt_state = RUN;
        end else if (step_pulse) begin
          nxt_state = STEP;
        end
      end
      RUN: begin
        if (ebreak_hit || bp_hit) begin
          nxt_state = HALT;
        end else if (!run_s) begin
          nxt_state = IDLE;
        end
      end
      STEP: begin
        nxt_state = ebreak_hit ? HALT : IDLE;
      end
      HALT: begin
        if (!run_s) begin
          nxt_state = IDLE;
        end else if (step_pulse) begin
          nxt_state = STEP;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= '0;
    end else if (cpu_en) begin
      retired <= retired + 32'd1;
    end
  end

  assign state  = cur_state;
  assign halted = (cur_state == HALT);

endmodule

// File: tb/tb_exec_controller.sv
// Directed self-checking bench for exec_controller: run, debounced step, ebreak, breakpoint and reset behaviour.
module tb_exec_controller;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] EBREAK = 32'h00100073;

  logic        clk;
  logic        rst;
  logic        run_req;
  logic        step_btn;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        cpu_en;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  exec_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .run_req  (run_req),
    .step_btn (step_btn),
    .bp_en    (bp_en),
    .bp_addr  (bp_addr),
    .pc       (pc),
    .instr    (instr),
    .cpu_en   (cpu_en),
    .state    (state),
    .halted   (halted),
    .retired  (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock; the pc advances like a core would when the cycle was enabled.
  task automatic tick();
    logic en;
    #1;
    en = cpu_en;
    @(posedge clk);
    #1;
    if (en) pc = pc + 32'd4;
    #1;
  endtask

  // Runs n clocks and counts how many post-edge cycles had cpu_en high.
  task automatic ticks(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cpu_en === 1'b1) highs++;
    end
  endtask

  // Holds step_btn for 8 clocks inside a 20-clock window; checks the STEP cycle.
  task automatic long_press(input string tag, input logic exp_halted, output int highs);
    highs = 0;
    step_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 9) step_btn = 1'b0;
      tick();
      if (cpu_en === 1'b1) highs++;
      if (i == 7) begin
        check({tag, "_step_state"}, 32'(state), 32'h2);
        check({tag, "_step_halted"}, 32'(halted), 32'(exp_halted));
      end
    end
  endtask

  initial begin
    int h;
    int h2;

    rst = 1'b1; run_req = 1'b0; step_btn = 1'b0; bp_en = 1'b0;
    bp_addr = 32'h0; pc = 32'h0; instr = NOP;
    ticks(2, h);
    check("rst_state",   32'(state),  32'h0);
    check("rst_cpu_en",  32'(cpu_en), 32'h0);
    check("rst_halted",  32'(halted), 32'h0);
    check("rst_retired", retired,     32'h0);

    // Free run: two synchronizer stages then the IDLE->RUN edge.
    rst = 1'b0; run_req = 1'b1;
    tick(); check("run_c1_en", 32'(cpu_en), 32'h0);
    tick(); check("run_c2_en", 32'(cpu_en), 32'h0);
    tick(); check("run_c3_en", 32'(cpu_en), 32'h1);
    check("run_c3_state", 32'(state), 32'h1);
    ticks(10, h);
    check("run_retired10", retired, 32'd10);
    check("run_state", 32'(state), 32'h1);
    run_req = 1'b0;
    ticks(3, h);
    check("stop_state", 32'(state), 32'h0);
    check("stop_retired", retired, 32'd13);
    check("stop_cpu_en", 32'(cpu_en), 32'h0);

    // A 2-cycle press is bounce and must not step.
    step_btn = 1'b1;
    ticks(2, h);
    step_btn = 1'b0;
    ticks(10, h2);
    check("short_press_en", 32'(h + h2), 32'h0);
    check("short_press_retired", retired, 32'd13);

    long_press("press", 1'b0, h);
    check("press_en_cycles", 32'(h), 32'h1);
    check("press_retired", retired, 32'd14);
    check("press_state", 32'(state), 32'h0);

    // ebreak halts RUN; a step from HALT on ebreak returns to HALT without retiring.
    run_req = 1'b1;
    ticks(3, h);
    check("eb_run_state", 32'(state), 32'h1);
    check("eb_run_retired", retired, 32'd14);
    ticks(2, h);
    check("eb_pre_retired", retired, 32'd16);
    instr = EBREAK;
    #1;
    check("eb_cpu_en", 32'(cpu_en), 32'h0);
    tick();
    check("eb_state", 32'(state), 32'h3);
    check("eb_halted", 32'(halted), 32'h1);
    check("eb_retired", retired, 32'd16);
    long_press("eb", 1'b0, h);
    check("eb_step_en_cycles", 32'(h), 32'h0);
    check("eb_step_state", 32'(state), 32'h3);
    check("eb_step_retired", retired, 32'd16);
    run_req = 1'b0;
    ticks(3, h);
    check("eb_release_state", 32'(state), 32'h0);
    check("eb_release_halted", 32'(halted), 32'h0);
    instr = NOP;

    // Breakpoint at 0x10 with the core starting at pc 0.
    pc = 32'h0; bp_en = 1'b1; bp_addr = 32'h10; run_req = 1'b1;
    ticks(3, h);
    check("bp_run_state", 32'(state), 32'h1);
    ticks(4, h);
    check("bp_pc", pc, 32'h10);
    check("bp_retired", retired, 32'd20);
`ifdef EXEC_CTRL_BREAKPOINT_EN
    check("bp_cpu_en", 32'(cpu_en), 32'h0);
    tick();
    check("bp_state", 32'(state), 32'h3);
    check("bp_halted", 32'(halted), 32'h1);
    check("bp_halt_retired", retired, 32'd20);
    run_req = 1'b0;
    ticks(3, h);
    check("bp_idle_state", 32'(state), 32'h0);
    run_req = 1'b1;
    ticks(3, h);
    check("bp_resume_state", 32'(state), 32'h1);
    check("bp_resume_en", 32'(cpu_en), 32'h1);
    tick();
    check("bp_resume_pc", pc, 32'h14);
    check("bp_resume_retired", retired, 32'd21);
    check("bp_resume_en2", 32'(cpu_en), 32'h1);
`else
    check("nobp_cpu_en", 32'(cpu_en), 32'h1);
    tick();
    check("nobp_state", 32'(state), 32'h1);
    check("nobp_retired", retired, 32'd21);
`endif
    ticks(4, h);
    check("pre_rst_retired", retired, 32'd25);
    check("pre_rst_state", 32'(state), 32'h1);

    // Reset in the middle of RUN.
    rst = 1'b1;
    tick();
    check("midrst_state", 32'(state), 32'h0);
    check("midrst_retired", retired, 32'h0);
    check("midrst_cpu_en", 32'(cpu_en), 32'h0);
    rst = 1'b0; run_req = 1'b0; bp_en = 1'b0;

    // Held button, then reset with the button released: no step afterwards.
    step_btn = 1'b1;
    ticks(10, h);
    check("held_en_cycles", 32'(h), 32'h1);
    check("held_retired", retired, 32'd1);
    rst = 1'b1; step_btn = 1'b0;
    ticks(2, h);
    rst = 1'b0;
    ticks(20, h);
    check("post_rst_en_cycles", 32'(h), 32'h0);
    check("post_rst_state", 32'(state), 32'h0);
    check("post_rst_retired", retired, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
